// File: rtl/adapter_fp_pkg.sv
// Shared types and constants for the 16-bit adapter FP datapath.
package adapter_fp_pkg;

    localparam int unsigned FP_EXP_W  = 5;
    localparam int unsigned FP_FRAC_W = 10;
    localparam int unsigned FPC_W     = 18;
    localparam int unsigned FP16_W    = 16;

    // FloPoCo exception field encoding
    typedef enum logic [1:0] {
        FPC_ZERO   = 2'b00,
        FPC_NORMAL = 2'b01,
        FPC_INF    = 2'b10,
        FPC_NAN    = 2'b11
    } fpc_exn_e;

    // FloPoCo word layout: {exn, sign, exp, frac}
    typedef struct packed {
        fpc_exn_e                 exn;
        logic                     sign;
        logic [FP_EXP_W-1:0]      exp;
        logic [FP_FRAC_W-1:0]     frac;
    } flopoco16_t;

    localparam logic [FP16_W-1:0] FP16_INF  = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_MAXF = 16'h7BFF;

endpackage

// File: rtl/fp16_pack_round.sv
// Combinational FloPoCo-to-binary16 packer with round-to-nearest-even for
// the subnormal path. Optional macro FP16_SATURATE_EN clamps overflow to
// max finite instead of infinity.
module fp16_pack_round
    import adapter_fp_pkg::*;
(
    input  logic [1:0]  exn_i,
    input  logic        sign_i,
    input  logic [4:0]  exp_i,
    input  logic [9:0]  frac_i,
    input  logic [9:0]  sub_mant_i,
    input  logic        guard_i,
    output logic [15:0] word_o,
    output logic        ovf_o,
    output logic        inexact_o,
    output logic        nan_o
);

    logic        rnd;
    logic [14:0] sub_mag;

    // Tie-only rounding: a lone guard bit is exactly half an ulp, so round up only on odd lsb.
    assign rnd     = guard_i & sub_mant_i[0];
    // Carry out of the mantissa lands in the exponent field, giving the min normal.
    assign sub_mag = 15'({5'b0, sub_mant_i}) + 15'(rnd);

    // Select the packed word and event flags by exception class.
    always_comb begin
        word_o    = '0;
        ovf_o     = 1'b0;
        inexact_o = 1'b0;
        nan_o     = 1'b0;
        case (fpc_exn_e'(exn_i))
            FPC_ZERO: word_o = {sign_i, 15'h0000};
            FPC_INF:  word_o = {sign_i, FP16_INF[14:0]};
            FPC_NAN: begin
                word_o = FP16_QNAN;
                nan_o  = 1'b1;
            end
            FPC_NORMAL: begin
                if (exp_i == 5'd31) begin
                    ovf_o = 1'b1;
`ifdef FP16_SATURATE_EN
                    word_o = {sign_i, FP16_MAXF[14:0]};
`else
                    word_o = {sign_i, FP16_INF[14:0]};
`endif
                end else if (exp_i == 5'd0) begin
                    word_o    = {sign_i, sub_mag};
                    inexact_o = guard_i;
                end else begin
                    word_o = {sign_i, exp_i, frac_i};
                end
            end
        endcase
    end

endmodule

// File: rtl/flopoco_to_fp16_stream.sv
// Two-stage valid/ready converter from FloPoCo 18-bit words to IEEE binary16,
// with sticky overflow/underflow flags and a saturating NaN counter.
// Optional macro FP16_SATURATE_EN (see fp16_pack_round) selects overflow saturation.
module flopoco_to_fp16_stream
    import adapter_fp_pkg::*;
#(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    input  logic             flags_clr,
    output logic             ovf_flag,
    output logic             unf_flag,
    output logic [CNT_W-1:0] nan_count
);

    // Only the binary16 geometry is implemented.
    if (EXP_W != 5) begin : g_exp_chk
        $error("flopoco_to_fp16_stream: EXP_W must be 5");
    end
    if (FRAC_W != 10) begin : g_frac_chk
        $error("flopoco_to_fp16_stream: FRAC_W must be 10");
    end

    flopoco16_t in_w;
    assign in_w = flopoco16_t'(in_data);

    logic             en_q, en_d;
    logic             s1_v_q, s1_v_d;
    fpc_exn_e         s1_exn_q, s1_exn_d;
    logic             s1_sign_q, s1_sign_d;
    logic [4:0]       s1_exp_q, s1_exp_d;
    logic [9:0]       s1_frac_q, s1_frac_d;
    logic [9:0]       s1_sub_q, s1_sub_d;
    logic             s1_guard_q, s1_guard_d;
    logic             s2_v_q, s2_v_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
    logic [CNT_W-1:0] cnt_base;

    logic        adv1, adv2, take_in, load2;
    logic [15:0] pk_word;
    logic        pk_ovf, pk_inexact, pk_nan;

    // Stall chain; en_q keeps the input closed during and just after reset.
    assign adv2     = !s2_v_q | out_ready;
    assign adv1     = en_q & (!s1_v_q | adv2);
    assign in_ready = adv1;
    assign take_in  = in_valid & adv1;
    assign load2    = s1_v_q & adv2;

    fp16_pack_round u_pack (
        .exn_i      (s1_exn_q),
        .sign_i     (s1_sign_q),
        .exp_i      (s1_exp_q),
        .frac_i     (s1_frac_q),
        .sub_mant_i (s1_sub_q),
        .guard_i    (s1_guard_q),
        .word_o     (pk_word),
        .ovf_o      (pk_ovf),
        .inexact_o  (pk_inexact),
        .nan_o      (pk_nan)
    );

    // Next-state for both pipeline stages and the sticky status.
    always_comb begin
        en_d       = 1'b1;
        s1_v_d     = s1_v_q;
        s1_exn_d   = s1_exn_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_sub_d   = s1_sub_q;
        s1_guard_d = s1_guard_q;
        s2_v_d     = s2_v_q;
        out_data_d = out_data_q;
        ovf_d      = flags_clr ? 1'b0 : ovf_q;
        unf_d      = flags_clr ? 1'b0 : unf_q;
        cnt_base   = flags_clr ? '0 : nan_cnt_q;
        nan_cnt_d  = cnt_base;

        if (adv1) begin
            s1_v_d = in_valid;
        end
        if (take_in) begin
            s1_exn_d   = in_w.exn;
            s1_sign_d  = in_w.sign;
            s1_exp_d   = in_w.exp;
            s1_frac_d  = in_w.frac;
            s1_sub_d   = {1'b1, in_w.frac[9:1]};
            s1_guard_d = in_w.frac[0];
        end

        if (adv2) begin
            s2_v_d = s1_v_q;
        end
        // Set events override a simultaneous clear.
        if (load2) begin
            out_data_d = pk_word;
            if (pk_ovf) begin
                ovf_d = 1'b1;
            end
            if (pk_inexact) begin
                unf_d = 1'b1;
            end
            if (pk_nan && (cnt_base != '1)) begin
                nan_cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_exn_q   <= FPC_ZERO;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_sub_q   <= '0;
            s1_guard_q <= 1'b0;
            s2_v_q     <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            nan_cnt_q  <= '0;
        end else begin
            en_q       <= en_d;
            s1_v_q     <= s1_v_d;
            s1_exn_q   <= s1_exn_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_frac_q  <= s1_frac_d;
            s1_sub_q   <= s1_sub_d;
            s1_guard_q <= s1_guard_d;
            s2_v_q     <= s2_v_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            nan_cnt_q  <= nan_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;
    assign ovf_flag  = ovf_q;
    assign unf_flag  = unf_q;
    assign nan_count = nan_cnt_q;

endmodule
